gb_timer: RTL
=============

Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer peripheral.
- Sits directly on the interconnect bus as a slave, alongside the CPU and memories.
- Decodes FF04–FF07, counts off a free-running 16-bit divider, and raises a one-clock timer interrupt request to the interrupt controller on TIMA overflow.

Parameters:
- BASE_ADDR, 16'hFF04: address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.
- RELOAD_DELAY, 4: clocks TIMA holds 8'h00 after overflow before the TMA reload and interrupt.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- bus_addr  input  16  interconnect address.
- bus_wr  input  1  write strobe; the write is sampled on the rising edge when high.
- bus_wdata  input  8  write data.
- bus_rdata  output  8  combinational read data for bus_addr.
- bus_hit  output  1  combinational; high when bus_addr is in BASE_ADDR..BASE_ADDR+3.
- int_timer  output  1  registered one-clock interrupt request pulse.

Behaviour:
- Reset (async, active-high):
  - div_cnt=16'h0000, TIMA=8'h00, TMA=8'h00, TAC=3'b000, reload counter idle, int_timer=0, last_sig=0.
  - Reset asserted mid-reload cancels the pending reload and interrupt.
- Divider:
  - div_cnt increments by 1 every clock and wraps FFFF→0000.
  - DIV reads div_cnt[15:8].
  - Any write to DIV clears div_cnt to 0 on that edge; bus_wdata is ignored.
- Tick signal: sig = TAC[2] & div_cnt[sel], where TAC[1:0] selects the bit:
  - 00 → bit 9
  - 01 → bit 3
  - 10 → bit 5
  - 11 → bit 7
- Increment edge detect:
  - last_sig registers sig each clock.
  - TIMA increments when last_sig=1 and sig=0 (falling edge).
  - A falling edge caused by a DIV clear or a TAC write (enable drop or select change) also increments TIMA. This is the intended glitch behaviour.
- Overflow:
  - Incrementing TIMA from FF sets TIMA=00 and loads the reload counter with RELOAD_DELAY.
  - The counter decrements each clock.
  - On the clock where it reaches 0: TIMA←TMA and int_timer=1 for exactly one clock.
- Reload state machine:
  - States: IDLE → DELAY (RELOAD_DELAY clocks) → RELOAD (1 clock) → IDLE.
  - RELOAD performs the TMA load and asserts int_timer.
- Boundary cases:
  - A TIMA write during DELAY takes effect and cancels both the reload and the interrupt.
  - A TIMA write in the RELOAD clock is ignored; TMA is loaded.
  - A TMA write in the RELOAD clock: the new bus_wdata is loaded into TIMA.
  - A TIMA write coinciding with an increment edge: the write wins, with no increment.
  - A falling edge during DELAY does not increment TIMA (TIMA stays 00).
- Reads (combinational, no side effects):
  - DIV → div_cnt[15:8]
  - TIMA → TIMA
  - TMA → TMA
  - TAC → {5'b11111, TAC}
  - When bus_hit=0, bus_rdata=8'hFF.
- Writes:
  - TAC stores bus_wdata[2:0].
  - Writes to addresses outside the window are ignored.
- Latency: a write is visible on bus_rdata in the clock after the write edge.

Test Plan:
- Reset, then no writes for 512 clocks → DIV reads 8'h02; TIMA=00; TAC reads F8; int_timer never asserted.
- TAC=3'b101, TMA=8'hA0, TIMA=8'hFE; wait 32 clocks → TIMA goes FF then 00; it holds 00 for 4 clocks, then becomes A0 with a one-clock int_timer pulse.
- Same setup, but write TIMA=8'h33 2 clocks into DELAY → TIMA=33, no int_timer, no reload.
- TAC=3'b101, run until div_cnt[3]=1, then write DIV → div_cnt=0 and TIMA increments by exactly 1.
- Assert reset 2 clocks into DELAY → all registers return to 0 immediately; int_timer stays 0 after release.
- Read bus_addr=16'hFF08 → bus_hit=0, bus_rdata=FF; write FF08 → no register changes.

Source files
------------

// File: rtl/gb_timer.sv
// gb_timer: memory-mapped DIV/TIMA/TMA/TAC timer slave.
// A free-running 16-bit divider feeds a selectable tap; falling edges of the
// gated tap increment TIMA. On TIMA overflow the counter reads 00 for
// RELOAD_DELAY clocks, then TMA is loaded and a one-clock interrupt is raised.
module gb_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int unsigned RELOAD_DELAY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  output logic        int_timer
);

  localparam int unsigned CNT_W = $clog2(RELOAD_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELOAD_DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [1:0] OFF_DIV  = 2'd0;
  localparam logic [1:0] OFF_TIMA = 2'd1;
  localparam logic [1:0] OFF_TMA  = 2'd2;
  localparam logic [1:0] OFF_TAC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  // Architectural state
  logic [15:0]      div_q;
  logic [7:0]       tima_q;
  logic [7:0]       tma_q;
  logic [2:0]       tac_q;
  logic             last_sig_q;
  logic             int_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Next-state values
  state_t           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       tima_d;
  logic             int_d;

  // Decode and tick signals
  logic [15:0] offset_c;
  logic        hit_c;
  logic        wr_div_c;
  logic        wr_tima_c;
  logic        wr_tma_c;
  logic        wr_tac_c;
  logic        tap_c;
  logic        sig_c;
  logic        fall_c;

  // Address window decode and per-register write strobes
  always_comb begin
    offset_c  = bus_addr - BASE_ADDR;
    hit_c     = (offset_c[15:2] == 14'd0);
    wr_div_c  = bus_wr & hit_c & (offset_c[1:0] == OFF_DIV);
    wr_tima_c = bus_wr & hit_c & (offset_c[1:0] == OFF_TIMA);
    wr_tma_c  = bus_wr & hit_c & (offset_c[1:0] == OFF_TMA);
    wr_tac_c  = bus_wr & hit_c & (offset_c[1:0] == OFF_TAC);
  end

  // Divider tap selected by TAC, gated by the enable bit; falling edge detect
  always_comb begin
    tap_c = 1'b0;
    unique case (tac_q[1:0])
      2'b00: tap_c = div_q[9];
      2'b01: tap_c = div_q[3];
      2'b10: tap_c = div_q[5];
      2'b11: tap_c = div_q[7];
      default: tap_c = 1'b0;
    endcase
    sig_c  = tac_q[2] & tap_c;
    // DIV clears and TAC writes may also produce an edge here, by design
    fall_c = last_sig_q & ~sig_c;
  end

  // Divider, configuration registers and edge-detect history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= 16'h0000;
      tma_q      <= 8'h00;
      tac_q      <= 3'b000;
      last_sig_q <= 1'b0;
    end else begin
      div_q      <= wr_div_c ? 16'h0000 : div_q + 16'd1;
      last_sig_q <= sig_c;
      if (wr_tma_c) begin
        tma_q <= bus_wdata;
      end
      if (wr_tac_c) begin
        tac_q <= bus_wdata[2:0];
      end
    end
  end

  // Reload state machine: state, delay counter, TIMA and interrupt registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tima_q  <= 8'h00;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      int_q   <= int_d;
    end
  end

  // Next-state logic: increment, overflow, delayed TMA reload and interrupt
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    int_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_tima_c) begin
          // A CPU write beats a simultaneous increment
          tima_d = bus_wdata;
        end else if (fall_c) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_DELAY;
            cnt_d   = CNT_LOAD;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_DELAY: begin
        // TIMA holds 00 and ignores ticks; a CPU write aborts the reload
        if (wr_tima_c) begin
          tima_d  = bus_wdata;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Load lands on entry to RELOAD so TMA and the pulse show together
          tima_d  = wr_tma_c ? bus_wdata : tma_q;
          int_d   = 1'b1;
          state_d = ST_RELOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_RELOAD: begin
        // TIMA writes are lost here; a TMA write is forwarded into TIMA
        state_d = ST_IDLE;
        if (wr_tma_c) begin
          tima_d = bus_wdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Side-effect-free read mux; FF outside the window
  always_comb begin
    bus_rdata = 8'hFF;
    if (hit_c) begin
      unique case (offset_c[1:0])
        OFF_DIV:  bus_rdata = div_q[15:8];
        OFF_TIMA: bus_rdata = tima_q;
        OFF_TMA:  bus_rdata = tma_q;
        OFF_TAC:  bus_rdata = {5'b11111, tac_q};
        default:  bus_rdata = 8'hFF;
      endcase
    end
  end

  assign bus_hit   = hit_c;
  assign int_timer = int_q;

endmodule
